// File: rtl/bus_xfer_pkg.sv
// Shared types and constants for the dual-bus transfer sequencer.
// Optional feature macro: BUS_XFER_SETTLE_EN (see bus_transfer_ctrl).
package bus_xfer_pkg;

    localparam int unsigned NREG_DEFAULT  = 8;
    localparam int unsigned IDX_W_DEFAULT = 3;

    localparam logic BUS_IN  = 1'b0;
    localparam logic BUS_IN2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/onehot_decoder.sv
// Index to one-hot decoder with enable; indices at or beyond NREG decode to all zeros.
module onehot_decoder #(
    parameter int unsigned IDX_W = 3,
    parameter int unsigned NREG  = 8
) (
    input  logic             en_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [NREG-1:0]  onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i && (32'(idx_i) < NREG)) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Register-to-register transfer sequencer driving Store/Load strobes onto bus IN or IN2.
// Define BUS_XFER_SETTLE_EN to insert a full DRIVE cycle before the Load strobe.
module bus_transfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int unsigned NREG  = NREG_DEFAULT,
    parameter int unsigned IDX_W = IDX_W_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_src,
    input  logic [IDX_W-1:0] req_dst,
    input  logic             req_bus,
    output logic [NREG-1:0]  Store,
    output logic [NREG-1:0]  Store2,
    output logic [NREG-1:0]  Load,
    output logic [NREG-1:0]  Load2,
    output logic             done,
    output logic             err
);

    xfer_state_e state_q, state_d;

    logic [IDX_W-1:0] src_q, src_d;
    logic [IDX_W-1:0] dst_q, dst_d;
    logic             bus_q, bus_d;

    logic [NREG-1:0] store_q, store_d;
    logic [NREG-1:0] store2_q, store2_d;
    logic [NREG-1:0] load_q, load_d;
    logic [NREG-1:0] load2_q, load2_d;

    logic ready_q, ready_d;
    logic done_q, done_d;
    logic err_q, err_d;

    logic            req_ok;
    logic            src_en, dst_en;
    logic [NREG-1:0] src_vec, dst_vec;

    assign req_ok = (req_src != req_dst) && (32'(req_src) < NREG) && (32'(req_dst) < NREG);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        bus_d   = bus_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    src_d = req_src;
                    dst_d = req_dst;
                    bus_d = req_bus;
                    if (req_ok) begin
`ifdef BUS_XFER_SETTLE_EN
                        state_d = DRIVE;
`else
                        state_d = LATCH;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DRIVE:   state_d = LATCH;
            LATCH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from next-state so every output comes straight from a flop.
    assign src_en = (state_d == DRIVE) || (state_d == LATCH);
    assign dst_en = (state_d == LATCH);

    onehot_decoder #(
        .IDX_W (IDX_W),
        .NREG  (NREG)
    ) u_src_dec (
        .en_i     (src_en),
        .idx_i    (src_d),
        .onehot_o (src_vec)
    );

    onehot_decoder #(
        .IDX_W (IDX_W),
        .NREG  (NREG)
    ) u_dst_dec (
        .en_i     (dst_en),
        .idx_i    (dst_d),
        .onehot_o (dst_vec)
    );

    always_comb begin
        store_d  = (bus_d == BUS_IN)  ? src_vec : '0;
        store2_d = (bus_d == BUS_IN2) ? src_vec : '0;
        load_d   = (bus_d == BUS_IN)  ? dst_vec : '0;
        load2_d  = (bus_d == BUS_IN2) ? dst_vec : '0;
        ready_d  = (state_d == IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            bus_q    <= 1'b0;
            store_q  <= '0;
            store2_q <= '0;
            load_q   <= '0;
            load2_q  <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            bus_q    <= bus_d;
            store_q  <= store_d;
            store2_q <= store2_d;
            load_q   <= load_d;
            load2_q  <= load2_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign Store     = store_q;
    assign Store2    = store2_q;
    assign Load      = load_q;
    assign Load2     = load2_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Directed self-checking bench for bus_transfer_ctrl; follows BUS_XFER_SETTLE_EN if defined.
module tb_bus_transfer_ctrl;

`ifdef BUS_XFER_SETTLE_EN
    localparam bit Settle = 1'b1;
`else
    localparam bit Settle = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_bus = 1'b0;
    logic [2:0] req_src = '0;
    logic [2:0] req_dst = '0;
    logic       req_ready, done, err;
    logic [7:0] Store, Store2, Load, Load2;

    logic [31:0] strobes;
    logic [2:0]  flags;

    int checks = 0;
    int errors = 0;

    assign strobes = {Store, Store2, Load, Load2};
    assign flags   = {req_ready, done, err};

    always #5 Clk = ~Clk;

    bus_transfer_ctrl #(
        .NREG  (8),
        .IDX_W (3)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_bus   (req_bus),
        .Store     (Store),
        .Store2    (Store2),
        .Load      (Load),
        .Load2     (Load2),
        .done      (done),
        .err       (err)
    );

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) cyc();
        checks++;
        if (strobes !== 32'h0) begin
            errors++;
            $display("FAIL reset_strobes: got %h want 00000000", strobes);
        end
        checks++;
        if (flags !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: got %b want 100", flags);
        end
        Reset = 1'b1;
        cyc();
        checks++;
        if (strobes !== 32'h0 || flags !== 3'b100) begin
            errors++;
            $display("FAIL post_reset_idle: got %h/%b want 00000000/100", strobes, flags);
        end
    endtask

    task automatic test_transfer(input string name, input logic [2:0] src, input logic [2:0] dst,
                                 input logic bus, input logic [31:0] drive_vec,
                                 input logic [31:0] both_vec);
        logic [31:0] exp_s [4];
        logic [2:0]  exp_f [4];
        int          n;
        exp_s = Settle ? '{drive_vec, both_vec, 32'h0, 32'h0} : '{both_vec, 32'h0, 32'h0, 32'h0};
        exp_f = Settle ? '{3'b000, 3'b000, 3'b010, 3'b100} : '{3'b000, 3'b010, 3'b100, 3'b100};
        n     = Settle ? 4 : 3;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_before: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_src   = src;
        req_dst   = dst;
        req_bus   = bus;
        cyc();
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (strobes !== exp_s[i]) begin
                errors++;
                $display("FAIL %s_strobes_c%0d: got %h want %h", name, i + 1, strobes, exp_s[i]);
            end
            checks++;
            if (flags !== exp_f[i]) begin
                errors++;
                $display("FAIL %s_flags_c%0d: got %b want %b", name, i + 1, flags, exp_f[i]);
            end
            cyc();
        end
    endtask

    task automatic test_error();
        logic [31:0] exp_acc;
        exp_acc = Settle ? {8'h02, 8'h00, 8'h00, 8'h00} : {8'h02, 8'h00, 8'h40, 8'h00};
        req_valid = 1'b1;
        req_src   = 3'd3;
        req_dst   = 3'd3;
        req_bus   = 1'b0;
        cyc();
        checks++;
        if (flags !== 3'b101 || strobes !== 32'h0) begin
            errors++;
            $display("FAIL err_same_idx: got %b/%h want 101/00000000", flags, strobes);
        end
        req_src = 3'd0;
        req_dst = 3'd0;
        req_bus = 1'b1;
        cyc();
        checks++;
        if (flags !== 3'b101 || strobes !== 32'h0) begin
            errors++;
            $display("FAIL err_back_to_back: got %b/%h want 101/00000000", flags, strobes);
        end
        req_src = 3'd1;
        req_dst = 3'd6;
        req_bus = 1'b0;
        cyc();
        req_valid = 1'b0;
        checks++;
        if (flags !== 3'b000 || strobes !== exp_acc) begin
            errors++;
            $display("FAIL err_then_accept: got %b/%h want 000/%h", flags, strobes, exp_acc);
        end
        repeat (Settle ? 3 : 2) cyc();
        checks++;
        if (flags !== 3'b100 || strobes !== 32'h0) begin
            errors++;
            $display("FAIL err_drain_idle: got %b/%h want 100/00000000", flags, strobes);
        end
    endtask

    task automatic test_held_request();
        logic [31:0] exp_s [8];
        logic [2:0]  exp_f [8];
        int          n;
        int          acc;
        exp_s = Settle ?
            '{{8'h02, 8'h00, 8'h00, 8'h00}, {8'h02, 8'h00, 8'h04, 8'h00}, 32'h0, 32'h0,
              {8'h00, 8'h10, 8'h00, 8'h00}, {8'h00, 8'h10, 8'h00, 8'h40}, 32'h0, 32'h0} :
            '{{8'h02, 8'h00, 8'h04, 8'h00}, 32'h0, 32'h0,
              {8'h00, 8'h10, 8'h00, 8'h40}, 32'h0, 32'h0, 32'h0, 32'h0};
        exp_f = Settle ?
            '{3'b000, 3'b000, 3'b010, 3'b100, 3'b000, 3'b000, 3'b010, 3'b100} :
            '{3'b000, 3'b010, 3'b100, 3'b000, 3'b010, 3'b100, 3'b100, 3'b100};
        n   = Settle ? 8 : 6;
        acc = Settle ? 3 : 2;
        req_valid = 1'b1;
        req_src   = 3'd1;
        req_dst   = 3'd2;
        req_bus   = 1'b0;
        cyc();
        req_src = 3'd4;
        req_dst = 3'd6;
        req_bus = 1'b1;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (strobes !== exp_s[i]) begin
                errors++;
                $display("FAIL held_strobes_c%0d: got %h want %h", i + 1, strobes, exp_s[i]);
            end
            checks++;
            if (flags !== exp_f[i]) begin
                errors++;
                $display("FAIL held_flags_c%0d: got %b want %b", i + 1, flags, exp_f[i]);
            end
            cyc();
            if (i == acc) req_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1;
        req_src   = 3'd6;
        req_dst   = 3'd1;
        req_bus   = 1'b1;
        cyc();
        req_valid = 1'b0;
        repeat (Settle ? 1 : 0) cyc();
        checks++;
        if (strobes !== {8'h00, 8'h40, 8'h00, 8'h02}) begin
            errors++;
            $display("FAIL midrst_latch: got %h want 00400002", strobes);
        end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (strobes !== 32'h0 || flags !== 3'b100) begin
            errors++;
            $display("FAIL midrst_async_drop: got %h/%b want 00000000/100", strobes, flags);
        end
        repeat (2) cyc();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (strobes !== 32'h0 || flags !== 3'b100) begin
                errors++;
                $display("FAIL midrst_after_c%0d: got %h/%b want 00000000/100", i + 1, strobes,
                         flags);
            end
        end
    endtask

    initial begin
        test_reset();
        test_transfer("xfer_2_5_in", 3'd2, 3'd5, 1'b0, {8'h04, 8'h00, 8'h00, 8'h00},
                      {8'h04, 8'h00, 8'h20, 8'h00});
        test_transfer("xfer_7_0_in2", 3'd7, 3'd0, 1'b1, {8'h00, 8'h80, 8'h00, 8'h00},
                      {8'h00, 8'h80, 8'h00, 8'h01});
        test_error();
        test_held_request();
        test_reset_mid();
        test_transfer("xfer_0_7_in", 3'd0, 3'd7, 1'b0, {8'h01, 8'h00, 8'h00, 8'h00},
                      {8'h01, 8'h00, 8'h80, 8'h00});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
